// File: rtl/vpu_pkg.sv
// Shared constants and lane-vector type for the vector datapath operand staging.
package vpu_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned MATRIX_SIZE = 3;

  typedef logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] lane_vec_t;

endpackage : vpu_pkg

// File: rtl/buffer_bank.sv
// One bank of MATRIX_SIZE lane registers, written as a whole vector, async active-low clear.
module buffer_bank
  import vpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = vpu_pkg::DATA_WIDTH,
  parameter int unsigned MATRIX_SIZE = vpu_pkg::MATRIX_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_in_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_out_flat
);

  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] lanes;

  for (genvar i = 0; i < int'(MATRIX_SIZE); i++) begin : g_lane
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lanes[i] <= '0;
      end else if (wr_en) begin
        lanes[i] <= data_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign data_out_flat = lanes;

endmodule : buffer_bank

// File: rtl/double_buffer_array.sv
// Ping-pong operand store: loads go to the inactive bank, a swap flips which bank drives the output.
module double_buffer_array
  import vpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = vpu_pkg::DATA_WIDTH,
  parameter int unsigned MATRIX_SIZE = vpu_pkg::MATRIX_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_en,
  input  logic                              swap_buffers,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_in_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_out_flat,
  output logic                              active_sel
);

  localparam int unsigned FLAT_W = DATA_WIDTH * MATRIX_SIZE;

  logic              sel;
  logic [1:0]        wr_en;
  logic [FLAT_W-1:0] bank_data [2];

  // A bank is written only while it is the inactive one (sampled before any swap at the same edge).
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en[b] = load_en & (sel != 1'(b));

    buffer_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MATRIX_SIZE (MATRIX_SIZE)
    ) u_bank (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en[b]),
      .data_in_flat  (data_in_flat),
      .data_out_flat (bank_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= 1'b0;
    end else if (swap_buffers) begin
      sel <= ~sel;
    end
  end

  // Unregistered so a swap is visible in the cycle right after its edge.
  assign data_out_flat = sel ? bank_data[1] : bank_data[0];
  assign active_sel    = sel;

endmodule : double_buffer_array

// File: tb/tb_double_buffer_array.sv
// Self-checking bench for double_buffer_array against a two-bank array reference model.
module tb_double_buffer_array;
  import vpu_pkg::*;

  localparam int unsigned FW = DATA_WIDTH * MATRIX_SIZE;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic          swap_buffers;
  logic [FW-1:0] data_in_flat;
  logic [FW-1:0] data_out_flat;
  logic          active_sel;

  int checks;
  int errors;

  logic [FW-1:0] ref_bank [2];
  logic          ref_sel;

  double_buffer_array dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .swap_buffers  (swap_buffers),
    .data_in_flat  (data_in_flat),
    .data_out_flat (data_out_flat),
    .active_sel    (active_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] pack3(input int a, input int b, input int c);
    lane_vec_t v;
    v[0] = DATA_WIDTH'(a);
    v[1] = DATA_WIDTH'(b);
    v[2] = DATA_WIDTH'(c);
    return FW'(v);
  endfunction

  function automatic void model_reset();
    ref_bank[0] = '0;
    ref_bank[1] = '0;
    ref_sel     = 1'b0;
  endfunction

  // Drives one clock of controls and advances the reference model by the same edge.
  task automatic drive_cycle(input logic ld, input logic sw, input logic [FW-1:0] d);
    @(negedge clk);
    load_en      = ld;
    swap_buffers = sw;
    data_in_flat = d;
    @(posedge clk);
    if (rst) begin
      if (ld) ref_bank[!ref_sel] = d;
      if (sw) ref_sel = !ref_sel;
    end
    #1;
    load_en      = 1'b0;
    swap_buffers = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out_flat !== '0 || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out=%h sel=%b expected out=0 sel=0", data_out_flat, active_sel);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_out_flat !== '0 || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out=%h sel=%b expected out=0 sel=0", data_out_flat, active_sel);
    end
  endtask

  task automatic test_load_swap();
    drive_cycle(1'b1, 1'b0, pack3(10, 20, 30));
    checks++;
    if (data_out_flat !== pack3(0, 0, 0)) begin
      errors++;
      $display("FAIL load_no_swap: out=%h expected %h", data_out_flat, pack3(0, 0, 0));
    end
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out_flat !== pack3(10, 20, 30) || active_sel !== 1'b1) begin
      errors++;
      $display("FAIL first_swap: out=%h sel=%b expected %h sel=1", data_out_flat, active_sel, pack3(10, 20, 30));
    end
    drive_cycle(1'b1, 1'b0, pack3(40, 50, 60));
    checks++;
    if (data_out_flat !== pack3(10, 20, 30)) begin
      errors++;
      $display("FAIL load_hidden: out=%h expected %h", data_out_flat, pack3(10, 20, 30));
    end
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out_flat !== pack3(40, 50, 60) || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL second_swap: out=%h sel=%b expected %h sel=0", data_out_flat, active_sel, pack3(40, 50, 60));
    end
  endtask

  task automatic test_repeat_swap();
    drive_cycle(1'b0, 1'b1, pack3(1, 2, 3));
    checks++;
    if (data_out_flat !== pack3(10, 20, 30)) begin
      errors++;
      $display("FAIL swap_back: out=%h expected %h", data_out_flat, pack3(10, 20, 30));
    end
    drive_cycle(1'b0, 1'b1, pack3(4, 5, 6));
    checks++;
    if (data_out_flat !== pack3(40, 50, 60)) begin
      errors++;
      $display("FAIL swap_forth: out=%h expected %h", data_out_flat, pack3(40, 50, 60));
    end
    drive_cycle(1'b0, 1'b0, pack3(99, 98, 97));
    checks++;
    if (data_out_flat !== pack3(40, 50, 60) || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: out=%h sel=%b expected %h sel=0", data_out_flat, active_sel, pack3(40, 50, 60));
    end
  endtask

  task automatic test_simultaneous();
    logic prev_sel;
    prev_sel = active_sel;
    drive_cycle(1'b1, 1'b1, pack3(7, 8, 9));
    checks++;
    if (data_out_flat !== pack3(7, 8, 9) || active_sel !== !prev_sel) begin
      errors++;
      $display("FAIL load_and_swap: out=%h sel=%b expected %h sel=%b", data_out_flat, active_sel, pack3(7, 8, 9), !prev_sel);
    end
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out_flat !== pack3(40, 50, 60)) begin
      errors++;
      $display("FAIL other_bank_kept: out=%h expected %h", data_out_flat, pack3(40, 50, 60));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (data_out_flat !== '0 || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h sel=%b expected out=0 sel=0", data_out_flat, active_sel);
    end
    #3;
    rst = 1'b1;
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out_flat !== '0 || active_sel !== 1'b1) begin
      errors++;
      $display("FAIL swap_after_reset: out=%h sel=%b expected out=0 sel=1", data_out_flat, active_sel);
    end
    // Reset held across an edge where both controls are asserted.
    @(negedge clk);
    load_en      = 1'b1;
    swap_buffers = 1'b1;
    data_in_flat = pack3(11, 22, 33);
    rst          = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (data_out_flat !== '0 || active_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: out=%h sel=%b expected out=0 sel=0", data_out_flat, active_sel);
    end
    load_en      = 1'b0;
    swap_buffers = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out_flat !== '0) begin
      errors++;
      $display("FAIL reset_cleared_both: out=%h expected 0", data_out_flat);
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] d;
    logic          ld;
    logic          sw;
    for (int n = 0; n < 300; n++) begin
      d  = FW'({$urandom, $urandom});
      ld = 1'($urandom_range(0, 1));
      sw = 1'($urandom_range(0, 2) == 0);
      drive_cycle(ld, sw, d);
      checks++;
      if (data_out_flat !== ref_bank[ref_sel] || active_sel !== ref_sel) begin
        errors++;
        $display("FAIL random[%0d]: out=%h sel=%b expected %h sel=%b", n, data_out_flat, active_sel, ref_bank[ref_sel], ref_sel);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    load_en      = 1'b0;
    swap_buffers = 1'b0;
    data_in_flat = '0;
    model_reset();
    test_reset();
    test_load_swap();
    test_repeat_swap();
    test_simultaneous();
    drive_cycle(1'b0, 1'b0, '0);
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_double_buffer_array
